seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 195 +++++++++++++++++++
 tb/tb_seq_alu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU (single-cycle ops, Booth multiplier, restoring divider when SEQ_ALU_DIV_EN is defined)
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               dz,
  output logic               illegal
);
  localparam int CNW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, dz_q, dz_d, ill_q, ill_d, qm1_q, qm1_d;
  logic res_dz, res_ill, last;
  logic [2*WIDTH-1:0] c_q, c_d, res;
  logic [WIDTH:0] acc_q, acc_d, sum, dif, mext, bsum;
  logic [WIDTH-1:0] lo_q, lo_d, m_q, m_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [SHW-1:0] sh;
`ifdef SEQ_ALU_DIV_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d, fit;
  logic [WIDTH:0] rsh, diff;
  logic [WIDTH-1:0] rn, qn, a_mag, b_mag;
`endif
  assign sh = B[SHW-1:0];
  assign sum = {1'b0, A} + {1'b0, B};
  assign dif = {1'b0, A} - {1'b0, B};
  assign mext = {m_q[WIDTH-1], m_q};
  assign bsum = {lo_q[0], qm1_q} == 2'b01 ? acc_q + mext :
                {lo_q[0], qm1_q} == 2'b10 ? acc_q - mext : acc_q;
  assign last = cnt_q == CNW'(WIDTH - 1);
`ifdef SEQ_ALU_DIV_EN
  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;
  assign rsh = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign diff = rsh - {1'b0, m_q};
  assign fit = ~diff[WIDTH];
  assign rn = fit ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
  assign qn = {lo_q[WIDTH-2:0], fit};
`endif
  always_comb begin
    res = '0;
    res_dz = 1'b0;
    res_ill = 1'b0;
    case (opcode)
      5'd1: res = {{(WIDTH-1){1'b0}}, sum};
      5'd2: res = {{(WIDTH-1){1'b0}}, dif};
      5'd3: ;
`ifdef SEQ_ALU_DIV_EN
      5'd4: begin
        res = {A, {WIDTH{1'b1}}};
        res_dz = 1'b1;
      end
`endif
      5'd5: res = {{WIDTH{1'b0}}, A >> sh};
      5'd6: res = {{WIDTH{1'b0}}, A << sh};
      5'd7: res = {{WIDTH{1'b0}}, $signed(A) >>> sh};
      5'd8: res = {{WIDTH{1'b0}}, (A >> sh) | (A << (WIDTH - int'(sh)))};
      5'd9: res = {{WIDTH{1'b0}}, (A << sh) | (A >> (WIDTH - int'(sh)))};
      5'd10: res = {{WIDTH{1'b0}}, A & B};
      5'd11: res = {{WIDTH{1'b0}}, A | B};
      5'd12: res = {{WIDTH{1'b0}}, -B};
      5'd13: res = {{WIDTH{1'b0}}, A ^ B};
      5'd14: res = {{WIDTH{1'b0}}, ~(A | B)};
      5'd15: res = {{WIDTH{1'b0}}, ~B};
      default: res_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    c_d = c_q;
    dz_d = dz_q;
    ill_d = ill_q;
    acc_d = acc_q;
    lo_d = lo_q;
    m_d = m_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
`ifdef SEQ_ALU_DIV_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
        cnt_d = '0;
        acc_d = '0;
        qm1_d = 1'b0;
        if (opcode == 5'd3) begin
          state_d = MUL;
          lo_d = B;
          m_d = A;
        end
`ifdef SEQ_ALU_DIV_EN
        else if (opcode == 5'd4 && B != '0) begin
          state_d = DIV;
          lo_d = a_mag;
          m_d = b_mag;
          qneg_d = A[WIDTH-1] ^ B[WIDTH-1];
          rneg_d = A[WIDTH-1];
        end
`endif
        else begin
          state_d = FIN;
          done_d = 1'b1;
          c_d = res;
          dz_d = res_dz;
          ill_d = res_ill;
        end
      end
      MUL: begin
        acc_d = {bsum[WIDTH], bsum[WIDTH:1]};
        lo_d = {bsum[0], lo_q[WIDTH-1:1]};
        qm1_d = lo_q[0];
        cnt_d = cnt_q + CNW'(1);
        if (last) begin
          state_d = FIN;
          done_d = 1'b1;
          c_d = {bsum, lo_q[WIDTH-1:1]};
          dz_d = 1'b0;
          ill_d = 1'b0;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      DIV: begin
        acc_d = {1'b0, rn};
        lo_d = qn;
        cnt_d = cnt_q + CNW'(1);
        if (last) begin
          state_d = FIN;
          done_d = 1'b1;
          c_d = {rneg_q ? -rn : rn, qneg_q ? -qn : qn};
          dz_d = 1'b0;
          ill_d = 1'b0;
        end
      end
`endif
      FIN: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      c_q <= '0;
      dz_q <= 1'b0;
      ill_q <= 1'b0;
      acc_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      c_q <= c_d;
      dz_q <= dz_d;
      ill_q <= ill_d;
      acc_q <= acc_d;
      lo_q <= lo_d;
      m_q <= m_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
`ifdef SEQ_ALU_DIV_EN
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign C = c_q;
  assign dz = dz_q;
  assign illegal = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu against a behavioural model
module tb_seq_alu;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start = 1'b0;
  logic [4:0] opcode = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic busy, done, dz, illegal;
  logic [63:0] C;
  int n_tests = 0;
  int n_fail = 0;
  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode), .A(A), .B(B),
    .busy(busy), .done(done), .C(C), .dz(dz), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] c, output logic edz, output logic eill, output int lat);
    longint sa, sb, q, r;
    logic [31:0] t;
    int s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = int'(b[4:0]);
    t = '0;
    c = '0;
    edz = 1'b0;
    eill = 1'b0;
    lat = 1;
    case (op)
      5'd1: c = {32'b0, a} + {32'b0, b};
      5'd2: c = ({32'b0, a} - {32'b0, b}) & 64'h1_FFFF_FFFF;
      5'd3: begin c = sa * sb; lat = 33; end
`ifdef SEQ_ALU_DIV_EN
      5'd4: if (b == 0) begin
        c = {a, 32'hFFFF_FFFF};
        edz = 1'b1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        c = {r[31:0], q[31:0]};
        lat = 33;
      end
`endif
      5'd5: begin t = a >> s; c = {32'b0, t}; end
      5'd6: begin t = a << s; c = {32'b0, t}; end
      5'd7: begin q = sa >>> s; c = {32'b0, q[31:0]}; end
      5'd8: begin t = a; for (int i = 0; i < s; i++) t = {t[0], t[31:1]}; c = {32'b0, t}; end
      5'd9: begin t = a; for (int i = 0; i < s; i++) t = {t[30:0], t[31]}; c = {32'b0, t}; end
      5'd10: c = {32'b0, a & b};
      5'd11: c = {32'b0, a | b};
      5'd12: begin t = 32'd0 - b; c = {32'b0, t}; end
      5'd13: c = {32'b0, a ^ b};
      5'd14: c = {32'b0, ~(a | b)};
      5'd15: c = {32'b0, ~b};
      default: eill = 1'b1;
    endcase
  endfunction
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [63:0] ec;
    logic edz, eill;
    int lat, n;
    model(op, a, b, ec, edz, eill, lat);
    opcode = op;
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    n = 1;
    start = 1'b0;
    check($sformatf("op%0d busy_after_accept", op), busy, 1);
    while (!done && n < 100) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        A = $urandom;
        B = $urandom;
        opcode = 5'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check($sformatf("op%0d latency", op), n, lat);
    check($sformatf("op%0d C a=%h b=%h", op, a, b), C, ec);
    check($sformatf("op%0d dz", op), dz, edz);
    check($sformatf("op%0d illegal", op), illegal, eill);
    check($sformatf("op%0d busy_at_done", op), busy, 1);
    start = 1'b1;
    opcode = 5'd1;
    A = $urandom;
    B = $urandom;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("op%0d fin_start_ignored", op), {busy, done}, 0);
    check($sformatf("op%0d C_held", op), C, ec);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] op;
    logic [31:0] a, b;
    bit saw;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset C", C, 0);
    check("reset dz", dz, 0);
    check("reset illegal", illegal, 0);
    clr = 1'b0;
    run_op(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("add carry const", C, 64'h0000_0001_0000_0000);
    run_op(5'd2, 32'd1, 32'd2, 1'b0);
    check("sub borrow const", C, 64'h0000_0001_FFFF_FFFF);
    run_op(5'd3, -32'sd3, 32'd7, 1'b1);
    check("mul -3*7 const", C, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(5'd3, 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(5'd3, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
`ifdef SEQ_ALU_DIV_EN
    run_op(5'd4, 32'd17, -32'sd5, 1'b1);
    check("div 17/-5 const", C, 64'h0000_0002_FFFF_FFFD);
    run_op(5'd4, 32'd17, 32'd0, 1'b0);
    check("div by zero const", C, 64'h0000_0011_FFFF_FFFF);
    check("div by zero dz", dz, 1);
    run_op(5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div min/-1 const", C, 64'h0000_0000_8000_0000);
    run_op(5'd4, -32'sd17, 32'd5, 1'b0);
    check("div -17/5 const", C, 64'hFFFF_FFFE_FFFF_FFFD);
`else
    run_op(5'd4, 32'd17, -32'sd5, 1'b1);
    check("div disabled illegal", illegal, 1);
    check("div disabled C", C, 0);
`endif
    run_op(5'd8, 32'h8000_0001, 32'd1, 1'b0);
    check("ror const", C, 64'h0000_0000_C000_0000);
    run_op(5'd7, 32'h8000_0000, 32'd31, 1'b0);
    check("shra const", C, 64'h0000_0000_FFFF_FFFF);
    run_op(5'd9, 32'h8000_0001, 32'd1, 1'b0);
    check("rol const", C, 64'h0000_0000_0000_0003);
    run_op(5'd8, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0);
    run_op(5'd7, 32'h8765_4321, 32'd0, 1'b0);
    run_op(5'd0, 32'd5, 32'd6, 1'b0);
    check("opcode0 illegal", illegal, 1);
    run_op(5'd20, 32'd5, 32'd6, 1'b0);
    check("opcode20 C", C, 0);
    opcode = 5'd3;
    A = $urandom;
    B = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort busy", busy, 0);
    check("abort C", C, 0);
    check("abort done", done, 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("abort no done", saw, 0);
    run_op(5'd1, 32'd2, 32'd3, 1'b0);
    check("add after abort", C, 64'd5);
    opcode = 5'd1;
    A = 32'd1;
    B = 32'd1;
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    check("clr beats start busy", busy, 0);
    @(negedge clk);
    check("clr beats start done", done, 0);
    repeat (300) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 15));
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(0, 31));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
